uart_tx_fifo: RTL

Parametrised UART transmitter with a built-in transmit FIFO. It is the successor to the single-byte transmitter and adds configurable data width, parity and stop bits. A valid/ready write port accepts words, which are serialised LSB-first on txd with no idle gap between queued frames. It sits between on-chip logic (or the top-level input pins) and the board UART pin.

---
 rtl/uart_tx_fifo.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with a built-in transmit FIFO. Queued words go out
//   LSB-first as start / data / optional parity / stop frames. While the
//   FIFO holds words, frames follow each other with no idle gap.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   wr_valid    write request
//   wr_data     word to transmit (DATA_BITS wide)
//   wr_ready    FIFO can accept a word (= !full)
//   txd         serial line, idles high, driven straight from a flop
//   busy        a frame is on the line (FSM not in IDLE)
//   tx_done     one-cycle pulse when the last stop bit of a frame completes
//   fifo_count  words queued, not counting the frame in flight
//
// Handshake: a word is stored on every rising edge where wr_valid && wr_ready
// are both high. wr_data is ignored on any other edge. wr_ready depends only
// on the registered count, so a write and a pop on the same edge leave the
// count unchanged. When the FIFO is full, writes are dropped until a pop
// frees a slot; wr_ready rises in the cycle after that pop.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic                          txd,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    // The baud counter also times the whole stop period, which can be 2 bits.
    localparam int BCW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int NW  = $clog2(DATA_BITS);

    localparam logic [BCW-1:0] BIT_LOAD   = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] STOP_LOAD  = BCW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [NW-1:0]  LAST_BIT   = NW'(DATA_BITS - 1);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]    CNT_ONE    = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_bit;
    logic [BCW-1:0]         baud_cnt;
    logic [NW-1:0]          bit_cnt;

    logic push;
    logic pop;
    logic baud_done;
    logic [DATA_BITS-1:0] head;

    assign wr_ready  = (fifo_count != FULL_COUNT);
    assign push      = wr_valid && wr_ready;
    assign baud_done = (baud_cnt == '0);
    assign head      = mem[rd_ptr];

    // A pop happens either from IDLE or on the very last stop-bit cycle, which
    // is what chains frames back-to-back without an idle cycle.
    always_comb begin
        pop = 1'b0;
        if (fifo_count != '0) begin
            if (state == S_IDLE) begin
                pop = 1'b1;
            end else if (state == S_STOP && baud_done) begin
                pop = 1'b1;
            end
        end
    end

    // Storage has no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_ONE;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_ONE;
            end

            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                end
                S_START: begin
                    if (baud_done) begin
                        txd       <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= '0;
                        baud_cnt  <= BIT_LOAD;
                        state     <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BCW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= BIT_LOAD;
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY != 0) begin
                                txd   <= parity_bit;
                                state <= S_PARITY;
                            end else begin
                                txd      <= 1'b1;
                                baud_cnt <= STOP_LOAD;
                                state    <= S_STOP;
                            end
                        end else begin
                            txd       <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + NW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BCW'(1);
                    end
                end
                S_PARITY: begin
                    if (baud_done) begin
                        txd      <= 1'b1;
                        baud_cnt <= STOP_LOAD;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - BCW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        tx_done <= 1'b1;
                        if (!pop) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BCW'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            // Frame launch, shared by IDLE and the last stop cycle. Placed
            // last so it overrides the per-state updates above.
            if (pop) begin
                shift_reg  <= head;
                parity_bit <= (PARITY == 1) ? ~(^head) : (^head);
                baud_cnt   <= BIT_LOAD;
                txd        <= 1'b0;
                busy       <= 1'b1;
                state      <= S_START;
            end
        end
    end

endmodule
